// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand path: sequencer state encoding and
// the select/flag field positions used by both the loader and muxsalida.
package alu_pkg;

  localparam int SEL_W    = 4;
  localparam int SEL_LSB  = 0;
  localparam int FLAG_BIT = 4;

  typedef enum logic [1:0] {
    CARGA_A  = 2'd0,
    CARGA_B  = 2'd1,
    CARGA_OP = 2'd2,
    EMITIR   = 2'd3
  } estado_t;

endpackage

// File: rtl/antirrebote.sv
// Button conditioning: 2-FF synchronizer, consecutive-cycle debounce and a
// one-cycle pulse on each debounced press. The synchronizer resets to the
// "pressed" level and the pulse is only armed after the button has been seen
// released, so a button held through reset never produces a spurious press.
module antirrebote #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          deb;
  logic          armed;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Debounce counter, accepted level, release-arming and rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= 1'b0;
      cnt   <= '0;
      armed <= 1'b0;
      pulso <= 1'b0;
    end else begin
      pulso <= 1'b0;
      if (!sync_2) begin
        armed <= 1'b1;
      end
      if (sync_2 != deb) begin
        if (cnt == LAST) begin
          deb   <= sync_2;
          cnt   <= '0;
          pulso <= sync_2 & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_carga_operandos.sv
// Operand-loading sequencer: captures A, B and then select/flag from the
// switches on successive debounced load presses, then offers the operation.
//
// Handshake: op_valid is high for as long as the sequencer sits in EMITIR and
// the operation fields are stable meanwhile; a transfer happens on a clock
// edge where op_valid && op_ready, after which op_valid drops. op_valid never
// falls without a transfer except on clear (which aborts it) or reset.
module alu_carga_operandos
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_cargar,
  input  logic             btn_borrar,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [SEL_W-1:0] sel,
  output logic             flag_in,
  output logic             op_valid,
  output logic [1:0]       estado
);

  estado_t st;
  estado_t st_nx;
  logic    pulso_cargar;
  logic    pulso_borrar;
  logic    load_a;
  logic    load_b;
  logic    load_op;
  logic    clr;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cargar (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_cargar),
    .pulso (pulso_cargar)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_borrar (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_borrar),
    .pulso (pulso_borrar)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= CARGA_A;
    end else begin
      st <= st_nx;
    end
  end

  // Next state and load strobes; clear overrides both load and handshake.
  always_comb begin
    st_nx   = st;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    clr     = 1'b0;
    if (pulso_borrar) begin
      clr   = 1'b1;
      st_nx = CARGA_A;
    end else begin
      case (st)
        CARGA_A: if (pulso_cargar) begin
          load_a = 1'b1;
          st_nx  = CARGA_B;
        end
        CARGA_B: if (pulso_cargar) begin
          load_b = 1'b1;
          st_nx  = CARGA_OP;
        end
        CARGA_OP: if (pulso_cargar) begin
          load_op = 1'b1;
          st_nx   = EMITIR;
        end
        EMITIR: if (op_ready) begin
          st_nx = CARGA_A;
        end
        default: st_nx = CARGA_A;
      endcase
    end
  end

  // Operand registers hold their values after the handshake for display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      sel     <= '0;
      flag_in <= 1'b0;
    end else if (clr) begin
      op_a    <= '0;
      op_b    <= '0;
      sel     <= '0;
      flag_in <= 1'b0;
    end else begin
      if (load_a) begin
        op_a <= sw;
      end
      if (load_b) begin
        op_b <= sw;
      end
      if (load_op) begin
        sel     <= sw[SEL_LSB +: SEL_W];
        flag_in <= sw[FLAG_BIT];
      end
    end
  end

  assign op_valid = (st == EMITIR);
  assign estado   = st;

endmodule

// File: tb/tb_alu_carga_operandos.sv
// Bench for alu_carga_operandos: button presses with random data, checked
// against a field-level model of the load/clear/handshake sequence.
module tb_alu_carga_operandos;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_cargar;
  logic       btn_borrar;
  logic       op_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] sel;
  logic       flag_in;
  logic       op_valid;
  logic [1:0] estado;

  int errors;
  int checks;

  // Reference model: which field comes next and what has been captured.
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [3:0] m_sel;
  logic       m_flag;
  int         m_stage;
  int         exp_acc;

  // Monitor state.
  int          acc_cnt;
  int          valid_cycles;
  logic        hs_pend;
  logic [20:0] hs_snap;

  logic [23:0] act;
  assign act = {op_a, op_b, sel, flag_in, op_valid, estado};

  alu_carga_operandos #(.WIDTH(8), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_cargar (btn_cargar),
    .btn_borrar (btn_borrar),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sel        (sel),
    .flag_in    (flag_in),
    .op_valid   (op_valid),
    .estado     (estado)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted-operation monitor: a transfer counts only if the operands are
  // still held and op_valid has dropped on the following cycle.
  initial begin
    acc_cnt      = 0;
    valid_cycles = 0;
    hs_pend      = 1'b0;
    hs_snap      = '0;
  end
  always @(posedge clk) begin
    if (hs_pend) begin
      if ({op_a, op_b, sel, flag_in} == hs_snap && !op_valid) acc_cnt++;
      hs_pend = 1'b0;
    end
    if (rst_n && op_valid && op_ready) begin
      hs_pend = 1'b1;
      hs_snap = {op_a, op_b, sel, flag_in};
    end
    if (rst_n && op_valid) valid_cycles++;
  end

  function automatic logic [23:0] exp_vec();
    logic [1:0] st;
    st = 2'(m_stage);
    return {m_a, m_b, m_sel, m_flag, (m_stage == 3), st};
  endfunction

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_sel = 4'h0; m_flag = 1'b0; m_stage = 0;
  endtask

  task automatic model_load(input logic [7:0] v);
    case (m_stage)
      0: begin m_a = v; m_stage = 1; end
      1: begin m_b = v; m_stage = 2; end
      2: begin m_sel = v[3:0]; m_flag = v[4]; m_stage = 3; end
      default: ;
    endcase
  endtask

  task automatic model_handshake();
    m_stage = 0;
    exp_acc++;
  endtask

  // Driver: clean press of the load button, then release and settle.
  task automatic press_cargar(input logic [7:0] v);
    @(negedge clk);
    sw = v;
    btn_cargar = 1'b1;
    repeat ($urandom_range(10, 16)) @(negedge clk);
    btn_cargar = 1'b0;
    repeat (12) @(negedge clk);
    sw = 8'($urandom);
    model_load(v);
  endtask

  task automatic press_borrar();
    @(negedge clk);
    btn_borrar = 1'b1;
    repeat ($urandom_range(10, 16)) @(negedge clk);
    btn_borrar = 1'b0;
    repeat (12) @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_held: got %h expected %h", act, exp_vec());
    end
    checks++;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_released: got %h expected %h", act, exp_vec());
    end
    checks++;
  endtask

  task automatic test_load();
    op_ready = 1'b0;
    press_cargar(8'h5A);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL load_a: got %h expected %h", act, exp_vec());
    end
    checks++;
    press_cargar(8'h3C);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL load_b: got %h expected %h", act, exp_vec());
    end
    checks++;
    press_cargar(8'h13);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL load_op: got %h expected %h", act, exp_vec());
    end
    checks++;
    repeat (20) @(negedge clk);
    if (act !== {8'h5A, 8'h3C, 4'd3, 1'b1, 1'b1, 2'd3}) begin
      errors++; $display("FAIL valid_held: got %h expected %h", act, {8'h5A, 8'h3C, 4'd3, 1'b1, 1'b1, 2'd3});
    end
    checks++;
  endtask

  task automatic test_handshake();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    model_handshake();
    if (act !== exp_vec()) begin
      errors++; $display("FAIL handshake: got %h expected %h", act, exp_vec());
    end
    checks++;
    repeat (2) @(negedge clk);
    if (acc_cnt !== exp_acc) begin
      errors++; $display("FAIL handshake_count: got %0d expected %0d", acc_cnt, exp_acc);
    end
    checks++;
  endtask

  task automatic test_bounce();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    @(negedge clk);
    sw = v;
    btn_cargar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      btn_cargar = ~btn_cargar;
    end
    btn_cargar = 1'b1;
    repeat (14) @(negedge clk);
    btn_cargar = 1'b0;
    repeat (12) @(negedge clk);
    model_load(v);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL bounce: got %h expected %h", act, exp_vec());
    end
    checks++;
  endtask

  task automatic test_clear_mid();
    press_borrar();
    if (act !== exp_vec()) begin
      errors++; $display("FAIL clear_idle: got %h expected %h", act, exp_vec());
    end
    checks++;
    press_cargar(8'hFF);
    press_cargar(8'h01);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL clear_pre: got %h expected %h", act, exp_vec());
    end
    checks++;
    press_borrar();
    if (act !== 24'h0) begin
      errors++; $display("FAIL clear_mid: got %h expected %h", act, 24'h0);
    end
    checks++;
  endtask

  task automatic test_clear_vs_handshake();
    int acc_before;
    press_cargar(8'($urandom_range(1, 255)));
    press_cargar(8'($urandom_range(1, 255)));
    press_cargar(8'($urandom_range(1, 255)));
    if (act !== exp_vec()) begin
      errors++; $display("FAIL cvh_emit: got %h expected %h", act, exp_vec());
    end
    checks++;
    acc_before = acc_cnt;
    // Clear pulse appears 2+DEB_CYCLES edges after a press driven on a
    // falling edge; raise op_ready for exactly that cycle.
    @(negedge clk);
    btn_borrar = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    repeat (10) @(negedge clk);
    btn_borrar = 1'b0;
    repeat (12) @(negedge clk);
    model_reset();
    if (act !== exp_vec()) begin
      errors++; $display("FAIL cvh_state: got %h expected %h", act, exp_vec());
    end
    checks++;
    if (acc_cnt !== acc_before || acc_cnt !== exp_acc) begin
      errors++; $display("FAIL cvh_count: got %0d expected %0d", acc_cnt, exp_acc);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int vc0;
    for (int n = 0; n < 4; n++) begin
      logic pre;
      pre = 1'($urandom_range(0, 1));
      op_ready = 1'b0;
      press_cargar(8'($urandom));
      press_cargar(8'($urandom));
      if (pre) op_ready = 1'b1;
      vc0 = valid_cycles;
      press_cargar(8'($urandom));
      if (pre) begin
        model_handshake();
        op_ready = 1'b0;
        if (valid_cycles - vc0 !== 1) begin
          errors++; $display("FAIL b2b_valid_len: got %0d expected %0d", valid_cycles - vc0, 1);
        end
        checks++;
      end else begin
        if (act !== exp_vec()) begin
          errors++; $display("FAIL b2b_emit: got %h expected %h", act, exp_vec());
        end
        checks++;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        model_handshake();
      end
      repeat (2) @(negedge clk);
      if (act !== exp_vec()) begin
        errors++; $display("FAIL b2b_after: got %h expected %h", act, exp_vec());
      end
      checks++;
      if (acc_cnt !== exp_acc) begin
        errors++; $display("FAIL b2b_count: got %0d expected %0d", acc_cnt, exp_acc);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] v;
    press_cargar(8'($urandom_range(1, 255)));
    press_cargar(8'($urandom_range(1, 255)));
    @(negedge clk);
    sw = 8'h33;
    btn_cargar = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    if (act !== exp_vec()) begin
      errors++; $display("FAIL async_reset: got %h expected %h", act, exp_vec());
    end
    checks++;
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL held_through_reset: got %h expected %h", act, exp_vec());
    end
    checks++;
    btn_cargar = 1'b0;
    repeat (12) @(negedge clk);
    v = 8'($urandom_range(1, 255));
    press_cargar(v);
    if (act !== exp_vec()) begin
      errors++; $display("FAIL repress_after_reset: got %h expected %h", act, exp_vec());
    end
    checks++;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    exp_acc    = 0;
    rst_n      = 1'b0;
    sw         = 8'h00;
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;
    op_ready   = 1'b0;
    model_reset();

    test_reset();
    test_load();
    test_handshake();
    test_bounce();
    test_clear_mid();
    test_clear_vs_handshake();
    test_back_to_back();
    test_async_reset();

    repeat (2) @(negedge clk);
    if (acc_cnt !== exp_acc) begin
      errors++; $display("FAIL final_count: got %0d expected %0d", acc_cnt, exp_acc);
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_carga_operandos.md
# alu_carga_operandos

Operand-loading sequencer directly upstream of the ALU output multiplexer (`muxsalida`). It captures operand A, operand B, then the operation select and input flag from the board switches, one field per debounced press of the load button. It then presents the complete operation to the ALU with a valid/ready handshake. A clear button aborts the sequence at any point.

## Interface
- `WIDTH`, default 8: operand width; must be ≥ 5.
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept a button level change; must be ≥ 1.
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sw`, in, WIDTH: raw board switches; no synchronizer needed, sampled only on accepted presses.
- `btn_cargar`, in, 1: raw load button, asynchronous to `clk`.
- `btn_borrar`, in, 1: raw clear button, asynchronous to `clk`.
- `op_ready`, in, 1: ALU stage accepts the operation.
- `op_a`, out, WIDTH: operand A register.
- `op_b`, out, WIDTH: operand B register.
- `sel`, out, 4: operation select (0–15) to the ALU mux.
- `flag_in`, out, 1: input flag (carry-in) to the ALU.
- `op_valid`, out, 1: operation complete and offered.
- `estado`, out, 2: current FSM state, for LEDs.

## Operation
- Reset (async, `rst_n`=0): `op_a`=0, `op_b`=0, `sel`=0, `flag_in`=0, `op_valid`=0, `estado`=CARGA_A. Debouncer levels and counters are cleared.
- Each button passes through the `antirrebote` path:
  - 2-FF synchronizer.
  - Debounce: the level `deb` takes the synchronized value once it has differed from `deb` for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - `pulso` is high for exactly one cycle on each 0→1 transition of `deb`.
- FSM states, in encoding order: CARGA_A=0, CARGA_B=1, CARGA_OP=2, EMITIR=3.
  - CARGA_A, on `pulso_cargar`: `op_a`←`sw`, then go to CARGA_B.
  - CARGA_B, on `pulso_cargar`: `op_b`←`sw`, then go to CARGA_OP.
  - CARGA_OP, on `pulso_cargar`: `sel`←`sw[3:0]`, `flag_in`←`sw[4]`, then go to EMITIR.
  - EMITIR: `op_valid`=1. On `op_valid && op_ready`, go to CARGA_A and drop `op_valid` the next cycle. `pulso_cargar` is ignored in this state.
- `op_a`, `op_b`, `sel` and `flag_in` hold their values after the handshake until overwritten by a new load. The ALU result therefore stays displayable.
- `pulso_borrar` in any state clears all operand registers to 0, sets `op_valid`=0 and goes to CARGA_A. It has priority over a simultaneous `pulso_cargar` and over a simultaneous handshake; the handshake is not completed.
- `op_valid` never deasserts without a handshake, except through clear or reset.
- Switch bits above bit 4 are ignored in CARGA_OP.

## Timing
- Raw button edge (held stable) → `pulso`: 2 + DEB_CYCLES cycles, +1 cycle of asynchronous sampling uncertainty.
- Register update on the `clk` edge where `pulso`=1. `estado` changes on that same edge.
- CARGA_OP load → `op_valid`=1 in the next cycle (registered output).
- If `op_ready`=1 is already high, the handshake completes in the first EMITIR cycle: `op_valid` is high for exactly 1 cycle.
- Button held down: a single `pulso`. Release followed by a new press is required for the next field.
- Reset asserted mid-sequence: outputs go to reset values immediately, without waiting for a clock. Deassertion is released synchronously by the board-level reset synchronizer, not by this block.

## Structure
- Package `alu_pkg`:
  - `estado_t` enum (CARGA_A, CARGA_B, CARGA_OP, EMITIR, 2 bits).
  - Constants `SEL_W`=4, `SEL_LSB`=0, `FLAG_BIT`=4.
  - Shared with `muxsalida` so both stages agree on select width.
- Sub-module `antirrebote`: synchronizer + debounce counter (`$clog2(DEB_CYCLES+1)` bits) + edge detect, parameterized by DEB_CYCLES. It is instantiated twice, once per button.
- Top: FSM and operand registers only.

## Test plan
- Reset then load sequence with WIDTH=8, DEB=4:
  - `sw`=0x5A press, 0x3C press, 0x13 press, `op_ready`=0.
  - Required: `op_a`=0x5A, `op_b`=0x3C, `sel`=3, `flag_in`=1, `op_valid`=1 held.
- Handshake: from the end of the previous scenario, assert `op_ready` for 1 cycle.
  - Required: `op_valid` falls next cycle and `estado`=0.
  - Required: operands remain 0x5A/0x3C/3/1.
- Bounce: toggle `btn_cargar` every 2 cycles for 12 cycles, then hold high.
  - Required: exactly one `pulso`, and only `op_a` is loaded.
- Clear mid-sequence: after loading A=0xFF and B=0x01, press `btn_borrar`.
  - Required: all operands are 0 and `estado`=CARGA_A.
- Clear vs. handshake: in EMITIR, with `pulso_borrar` and `op_ready` coinciding.
  - Required: clear wins, `op_valid`=0, and no accepted operation is counted by the monitor.
- Async reset mid-debounce, pulsed between clock edges:
  - Required: outputs zero immediately.
  - Required: a button held high through reset produces no `pulso` until it has been released and pressed again.
